// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: sequences fetch, decode, execute, memory and
// write-back, and drives the datapath enables, mux selects and ALU code.

package AluCtrlSig_pkg;
  // Primary opcodes (instr[31:26])
  localparam logic [5:0] ADD_op  = 6'h00;  // R-type
  localparam logic [5:0] LW_op   = 6'h23;
  localparam logic [5:0] SW_op   = 6'h2B;
  localparam logic [5:0] J_op    = 6'h02;
  localparam logic [5:0] BEQ_op  = 6'h04;
  localparam logic [5:0] BNE_op  = 6'h05;
  localparam logic [5:0] ADDI_op = 6'h08;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_XOR = 6'h26;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_XOR = 4'd13;

  // Controller states; the encoding is visible on state_o
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_ALUWB    = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;
endpackage

module mips_mc_ctrl
  import AluCtrlSig_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  pc_src,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [3:0]  state_o
);

  state_t     state_q, state_d;
  logic       reset_done_q;   // RESET has already spent one cycle after release
  logic [5:0] opcode_q;
  logic [5:0] funct_q;
  logic       funct_ill_q;    // R-type funct was undecodable; blocks write-back
  logic [3:0] rtype_ctrl;
  logic       rtype_ill;

  // Only the opcode and funct fields steer the sequence.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  assign state_o = state_q;

  // Map the latched funct onto an ALU code; unknown functs fall back to ADD.
  always_comb begin
    rtype_ill = 1'b0;
    case (funct_q)
      F_ADD:   rtype_ctrl = ALU_ADD;
      F_SUB:   rtype_ctrl = ALU_SUB;
      F_AND:   rtype_ctrl = ALU_AND;
      F_OR:    rtype_ctrl = ALU_OR;
      F_NOR:   rtype_ctrl = ALU_NOR;
      F_SLT:   rtype_ctrl = ALU_SLT;
      F_XOR:   rtype_ctrl = ALU_XOR;
      default: begin
        rtype_ctrl = ALU_ADD;
        rtype_ill  = 1'b1;
      end
    endcase
  end

  // Next-state and datapath control decode, combinational from the state.
  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves a signal unassigned and infers a latch.
    state_d    = state_q;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_ctrl   = 4'd0;
    pc_src     = 2'd0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      // One idle cycle after release so the first FETCH lands on the second edge.
      S_RESET: state_d = reset_done_q ? S_FETCH : S_RESET;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // IR was loaded at the end of FETCH, so the opcode is read live here.
        alu_src_b = 2'd3;
        alu_ctrl  = ALU_ADD;
        case (instr[31:26])
          LW_op, SW_op:   state_d = S_MEMADR;
          ADD_op:         state_d = S_RTYPE_EX;
          ADDI_op:        state_d = S_ADDI_EX;
          BEQ_op, BNE_op: state_d = S_BRANCH;
          J_op:           state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctrl  = ALU_ADD;
        state_d   = (opcode_q == SW_op) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_RTYPE_EX: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = rtype_ctrl;
        illegal_op = rtype_ill;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = (opcode_q == ADD_op);
        reg_write  = (opcode_q == ADDI_op) || !funct_ill_q;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctrl  = ALU_ADD;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_src     = 2'd1;
        pc_en      = (opcode_q == BEQ_op) ? zero : !zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'd2;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

  // State register plus opcode/funct capture for the rest of the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q      <= S_RESET;
      reset_done_q <= 1'b0;
      opcode_q     <= 6'd0;
      funct_q      <= 6'd0;
      funct_ill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_RESET) reset_done_q <= 1'b1;
      if (state_q == S_DECODE) begin
        opcode_q <= instr[31:26];
        funct_q  <= instr[5:0];
      end
      if (state_q == S_RTYPE_EX) funct_ill_q <= rtype_ill;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle state and control vectors.
module tb_mips_mc_ctrl;
  import AluCtrlSig_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  alu_ctrl, state_o;

  int checks = 0;
  int errors = 0;

  mips_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .pc_src(pc_src), .instr_done(instr_done),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  wire [18:0] outs = {pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write,
                      reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
                      pc_src, instr_done, illegal_op};

  typedef struct {
    logic        mr;
    logic        z;
    logic [31:0] ins;
    logic [3:0]  st;
    logic [18:0] o;
  } vec_t;

  // Pack expected controls in the same order as 'outs'.
  function automatic logic [18:0] ex(input logic pe, irw, iod, mrd, mwr, rw, rdst, m2r, asa,
                                     input logic [1:0] asb, input logic [3:0] ac,
                                     input logic [1:0] ps, input logic done, ill);
    return {pe, irw, iod, mrd, mwr, rw, rdst, m2r, asa, asb, ac, ps, done, ill};
  endfunction

  function automatic logic [18:0] o_fetch(input logic go);
    return ex(go, go, 0, 1, 0, 0, 0, 0, 0, 2'd1, 4'd2, 2'd0, 0, 0);
  endfunction
  function automatic logic [18:0] o_decode(input logic ill);
    return ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 4'd2, 2'd0, ill, ill);
  endfunction
  function automatic logic [18:0] o_memadr();
    return ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 4'd2, 2'd0, 0, 0);
  endfunction
  function automatic logic [18:0] o_memrd();
    return ex(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 4'd0, 2'd0, 0, 0);
  endfunction
  function automatic logic [18:0] o_memwb();
    return ex(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 4'd0, 2'd0, 1, 0);
  endfunction
  function automatic logic [18:0] o_memwr(input logic go);
    return ex(0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 4'd0, 2'd0, go, 0);
  endfunction
  function automatic logic [18:0] o_rtype(input logic [3:0] ac, input logic ill);
    return ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, ac, 2'd0, 0, ill);
  endfunction
  function automatic logic [18:0] o_aluwb(input logic rw, rdst);
    return ex(0, 0, 0, 0, 0, rw, rdst, 0, 0, 2'd0, 4'd0, 2'd0, 1, 0);
  endfunction
  function automatic logic [18:0] o_branch(input logic pe);
    return ex(pe, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 4'd6, 2'd1, 1, 0);
  endfunction
  function automatic logic [18:0] o_jump();
    return ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 2'd2, 1, 0);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({state_o, outs} !== {4'd0, 19'd0}) begin
      errors++;
      $display("FAIL reset_hold state/outs got %h/%h want 0/0", state_o, outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({state_o, outs} !== {4'd0, 19'd0}) begin
      errors++;
      $display("FAIL reset_first_edge state/outs got %h/%h want 0/0", state_o, outs);
    end
  endtask

  // add $8,$9,$10; instr changes to a LW after DECODE and must be ignored.
  task automatic test_rtype_add();
    vec_t v[4];
    v[0] = '{1'b1, 1'b0, 32'h012A4020, S_FETCH,    o_fetch(1)};
    v[1] = '{1'b1, 1'b0, 32'h012A4020, S_DECODE,   o_decode(0)};
    v[2] = '{1'b1, 1'b0, 32'h8D280004, S_RTYPE_EX, o_rtype(4'd2, 0)};
    v[3] = '{1'b1, 1'b0, 32'h8D280004, S_ALUWB,    o_aluwb(1, 1)};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = v[i].mr; zero = v[i].z; instr = v[i].ins;
      #1;
      checks++;
      if ({state_o, outs} !== {v[i].st, v[i].o}) begin
        errors++;
        $display("FAIL add cyc%0d state/outs got %h/%h want %h/%h", i, state_o, outs, v[i].st, v[i].o);
      end
    end
  endtask

  task automatic test_funct_sweep();
    logic [5:0] fn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h26, 6'h3F};
    logic [3:0] ac [8] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7, 4'd13, 4'd2};
    vec_t v[4];
    for (int f = 0; f < 8; f++) begin
      logic [31:0] ins;
      logic        ill;
      ins = {6'h00, 5'd9, 5'd10, 5'd8, 5'd0, fn[f]};
      ill = (f == 7);
      v[0] = '{1'b1, 1'b0, ins, S_FETCH,    o_fetch(1)};
      v[1] = '{1'b1, 1'b0, ins, S_DECODE,   o_decode(0)};
      v[2] = '{1'b1, 1'b0, ins, S_RTYPE_EX, o_rtype(ac[f], ill)};
      v[3] = '{1'b1, 1'b0, ins, S_ALUWB,    o_aluwb(!ill, 1)};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        mem_ready = v[i].mr; zero = v[i].z; instr = v[i].ins;
        #1;
        checks++;
        if ({state_o, outs} !== {v[i].st, v[i].o}) begin
          errors++;
          $display("FAIL funct%h cyc%0d state/outs got %h/%h want %h/%h", fn[f], i, state_o, outs, v[i].st, v[i].o);
        end
      end
    end
  endtask

  // LW with three wait cycles in MEMRD; mem_ready high in DECODE/MEMADR is ignored.
  task automatic test_load();
    vec_t v[8];
    v[0] = '{1'b1, 1'b0, 32'h8D280004, S_FETCH,  o_fetch(1)};
    v[1] = '{1'b1, 1'b0, 32'h8D280004, S_DECODE, o_decode(0)};
    v[2] = '{1'b1, 1'b0, 32'h8D280004, S_MEMADR, o_memadr()};
    v[3] = '{1'b0, 1'b0, 32'h8D280004, S_MEMRD,  o_memrd()};
    v[4] = '{1'b0, 1'b0, 32'h8D280004, S_MEMRD,  o_memrd()};
    v[5] = '{1'b0, 1'b0, 32'h8D280004, S_MEMRD,  o_memrd()};
    v[6] = '{1'b1, 1'b0, 32'h8D280004, S_MEMRD,  o_memrd()};
    v[7] = '{1'b1, 1'b0, 32'h8D280004, S_MEMWB,  o_memwb()};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_ready = v[i].mr; zero = v[i].z; instr = v[i].ins;
      #1;
      checks++;
      if ({state_o, outs} !== {v[i].st, v[i].o}) begin
        errors++;
        $display("FAIL lw cyc%0d state/outs got %h/%h want %h/%h", i, state_o, outs, v[i].st, v[i].o);
      end
    end
  endtask

  // SW with FETCH and MEMWR wait states, then a waiting FETCH with no instr_done.
  task automatic test_store();
    vec_t v[8];
    v[0] = '{1'b0, 1'b0, 32'hAD280004, S_FETCH,  o_fetch(0)};
    v[1] = '{1'b0, 1'b0, 32'hAD280004, S_FETCH,  o_fetch(0)};
    v[2] = '{1'b1, 1'b0, 32'hAD280004, S_FETCH,  o_fetch(1)};
    v[3] = '{1'b0, 1'b0, 32'hAD280004, S_DECODE, o_decode(0)};
    v[4] = '{1'b0, 1'b0, 32'hAD280004, S_MEMADR, o_memadr()};
    v[5] = '{1'b0, 1'b0, 32'hAD280004, S_MEMWR,  o_memwr(0)};
    v[6] = '{1'b1, 1'b0, 32'hAD280004, S_MEMWR,  o_memwr(1)};
    v[7] = '{1'b0, 1'b0, 32'hAD280004, S_FETCH,  o_fetch(0)};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_ready = v[i].mr; zero = v[i].z; instr = v[i].ins;
      #1;
      checks++;
      if ({state_o, outs} !== {v[i].st, v[i].o}) begin
        errors++;
        $display("FAIL sw cyc%0d state/outs got %h/%h want %h/%h", i, state_o, outs, v[i].st, v[i].o);
      end
    end
  endtask

  task automatic test_branch();
    vec_t v[12];
    v[0]  = '{1'b1, 1'b1, 32'h11090003, S_FETCH,  o_fetch(1)};
    v[1]  = '{1'b1, 1'b1, 32'h11090003, S_DECODE, o_decode(0)};
    v[2]  = '{1'b1, 1'b1, 32'h11090003, S_BRANCH, o_branch(1)};
    v[3]  = '{1'b1, 1'b1, 32'h15090003, S_FETCH,  o_fetch(1)};
    v[4]  = '{1'b1, 1'b1, 32'h15090003, S_DECODE, o_decode(0)};
    v[5]  = '{1'b1, 1'b1, 32'h15090003, S_BRANCH, o_branch(0)};
    v[6]  = '{1'b1, 1'b0, 32'h15090003, S_FETCH,  o_fetch(1)};
    v[7]  = '{1'b1, 1'b0, 32'h15090003, S_DECODE, o_decode(0)};
    v[8]  = '{1'b1, 1'b0, 32'h15090003, S_BRANCH, o_branch(1)};
    v[9]  = '{1'b1, 1'b0, 32'h11090003, S_FETCH,  o_fetch(1)};
    v[10] = '{1'b1, 1'b0, 32'h11090003, S_DECODE, o_decode(0)};
    v[11] = '{1'b1, 1'b0, 32'h11090003, S_BRANCH, o_branch(0)};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mem_ready = v[i].mr; zero = v[i].z; instr = v[i].ins;
      #1;
      checks++;
      if ({state_o, outs} !== {v[i].st, v[i].o}) begin
        errors++;
        $display("FAIL branch cyc%0d state/outs got %h/%h want %h/%h", i, state_o, outs, v[i].st, v[i].o);
      end
    end
  endtask

  // Illegal opcode, jump and ADDI back to back.
  task automatic test_back_to_back();
    vec_t v[9];
    v[0] = '{1'b1, 1'b0, 32'hFC000000, S_FETCH,   o_fetch(1)};
    v[1] = '{1'b1, 1'b0, 32'hFC000000, S_DECODE,  o_decode(1)};
    v[2] = '{1'b1, 1'b0, 32'h08000010, S_FETCH,   o_fetch(1)};
    v[3] = '{1'b1, 1'b0, 32'h08000010, S_DECODE,  o_decode(0)};
    v[4] = '{1'b1, 1'b0, 32'h08000010, S_JUMP,    o_jump()};
    v[5] = '{1'b1, 1'b0, 32'h21280005, S_FETCH,   o_fetch(1)};
    v[6] = '{1'b1, 1'b0, 32'h21280005, S_DECODE,  o_decode(0)};
    v[7] = '{1'b1, 1'b0, 32'h21280005, S_ADDI_EX, o_memadr()};
    v[8] = '{1'b1, 1'b0, 32'h21280005, S_ALUWB,   o_aluwb(1, 0)};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mem_ready = v[i].mr; zero = v[i].z; instr = v[i].ins;
      #1;
      checks++;
      if ({state_o, outs} !== {v[i].st, v[i].o}) begin
        errors++;
        $display("FAIL b2b cyc%0d state/outs got %h/%h want %h/%h", i, state_o, outs, v[i].st, v[i].o);
      end
    end
  endtask

  // Reset asserted mid-MEMWR between clock edges, then released.
  task automatic test_reset_mid_store();
    vec_t v[4];
    v[0] = '{1'b1, 1'b0, 32'hAD280004, S_FETCH,  o_fetch(1)};
    v[1] = '{1'b1, 1'b0, 32'hAD280004, S_DECODE, o_decode(0)};
    v[2] = '{1'b1, 1'b0, 32'hAD280004, S_MEMADR, o_memadr()};
    v[3] = '{1'b0, 1'b0, 32'hAD280004, S_MEMWR,  o_memwr(0)};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = v[i].mr; zero = v[i].z; instr = v[i].ins;
      #1;
      checks++;
      if ({state_o, outs} !== {v[i].st, v[i].o}) begin
        errors++;
        $display("FAIL swrst cyc%0d state/outs got %h/%h want %h/%h", i, state_o, outs, v[i].st, v[i].o);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state_o, outs} !== {4'd0, 19'd0}) begin
      errors++;
      $display("FAIL async_rst state/outs got %h/%h want 0/0", state_o, outs);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({state_o, outs} !== {4'd0, 19'd0}) begin
      errors++;
      $display("FAIL post_rst_reset state/outs got %h/%h want 0/0", state_o, outs);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({state_o, outs} !== {4'(S_FETCH), o_fetch(1)}) begin
      errors++;
      $display("FAIL post_rst_fetch state/outs got %h/%h want %h/%h", state_o, outs, S_FETCH, o_fetch(1));
    end
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_funct_sweep();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
